// File: rtl/frame_bank_sched.sv
// Triple-buffer bank scheduler between a camera write stream and an HDMI reader.
// Optional `FRAME_DROP_CNT_EN adds a saturating drop_cnt output for overwritten pending frames.
module frame_bank_sched #(
    parameter int LINES       = 480,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       s_tvalid,
    input  logic       s_tready,
    input  logic       s_tuser,
    input  logic       s_tlast,
    input  logic       rd_vsync,
    output logic [1:0] wr_bank,
    output logic [1:0] rd_bank,
    output logic       wr_en,
    output logic       frame_ready,
    output logic       err_short,
    output logic [9:0] line_cnt
`ifdef FRAME_DROP_CNT_EN
    ,
    output logic [15:0] drop_cnt
`endif
);

    typedef enum logic {
        W_IDLE,
        W_ACTIVE
    } wstate_t;

    localparam logic [9:0] LAST_LINE = 10'(LINES - 1);

    wstate_t state, state_nxt;
    logic [9:0] line_nxt;
    logic       beat;
    logic       commit;
    logic       restart;
    logic [1:0] pend_bank;

    logic [SYNC_STAGES-1:0] vsync_p;
    logic                   vsync_q;
    logic                   rd_evt;

    assign beat = s_tvalid & s_tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= W_IDLE;
            line_cnt  <= '0;
            err_short <= 1'b0;
        end else begin
            state     <= state_nxt;
            line_cnt  <= line_nxt;
            err_short <= restart;
        end
    end

    // A tuser beat always wins over tlast: a restarted frame never commits.
    always_comb begin
        state_nxt = state;
        line_nxt  = line_cnt;
        commit    = 1'b0;
        restart   = 1'b0;
        wr_en     = 1'b0;
        case (state)
            W_IDLE: begin
                wr_en = s_tvalid & s_tuser;
                if (beat && s_tuser) begin
                    state_nxt = W_ACTIVE;
                    line_nxt  = '0;
                end
            end
            W_ACTIVE: begin
                wr_en = 1'b1;
                if (beat && s_tuser) begin
                    restart  = 1'b1;
                    line_nxt = '0;
                end else if (beat && s_tlast) begin
                    if (line_cnt == LAST_LINE) begin
                        commit    = 1'b1;
                        line_nxt  = '0;
                        state_nxt = W_IDLE;
                    end else begin
                        line_nxt = line_cnt + 10'd1;
                    end
                end
            end
        endcase
    end

    // Synchronizer stages followed by the edge register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_p <= '0;
            vsync_q <= 1'b0;
        end else begin
            vsync_p <= {vsync_p[SYNC_STAGES-2:0], rd_vsync};
            vsync_q <= vsync_p[SYNC_STAGES-1];
        end
    end

    assign rd_evt = vsync_p[SYNC_STAGES-1] & ~vsync_q;

    // Bank rotation: the three indices are only ever permuted, so they stay distinct.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank     <= 2'd0;
            pend_bank   <= 2'd1;
            rd_bank     <= 2'd2;
            frame_ready <= 1'b0;
        end else if (commit && rd_evt) begin
            rd_bank     <= wr_bank;
            wr_bank     <= pend_bank;
            pend_bank   <= rd_bank;
            frame_ready <= 1'b0;
        end else if (commit) begin
            wr_bank     <= pend_bank;
            pend_bank   <= wr_bank;
            frame_ready <= 1'b1;
        end else if (rd_evt && frame_ready) begin
            rd_bank     <= pend_bank;
            pend_bank   <= rd_bank;
            frame_ready <= 1'b0;
        end
    end

`ifdef FRAME_DROP_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= '0;
        end else if (commit && !rd_evt && frame_ready && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_bank_sched.sv
// Scoreboard bench for frame_bank_sched (LINES=4): directed scenarios followed by random traffic,
// predicted by a frame-level reference model and compared by an independent monitor.
module tb_frame_bank_sched;

    localparam int LINES = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       v = 1'b0, r = 1'b0, u = 1'b0, l = 1'b0, vs = 1'b0;
    logic [1:0] wr_bank, rd_bank;
    logic       wr_en, frame_ready, err_short;
    logic [9:0] line_cnt;
    logic [15:0] drop_val;
`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop_cnt;
    assign drop_val = drop_cnt;
`else
    assign drop_val = 16'd0;
`endif

    always #5 clk = ~clk;

    frame_bank_sched #(.LINES(LINES), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rstn(rstn),
        .s_tvalid(v), .s_tready(r), .s_tuser(u), .s_tlast(l),
        .rd_vsync(vs),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .wr_en(wr_en),
        .frame_ready(frame_ready), .err_short(err_short), .line_cnt(line_cnt)
`ifdef FRAME_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    typedef struct {
        logic [1:0]  w;
        logic [1:0]  r;
        logic        fr;
        logic        err;
        logic        we;
        logic [9:0]  ln;
        logic [15:0] dc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference model: bank roles, frame progress and scheduled read events
    int m_w, m_r, m_p, m_line, m_drop, cyc;
    bit m_fr, m_err, m_act, m_prev_vs;
    int due[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_w = 0; m_p = 1; m_r = 2;
        m_fr = 0; m_err = 0; m_act = 0; m_line = 0; m_drop = 0;
        m_prev_vs = 0;
        due.delete();
    endtask

    task automatic model_step();
        bit beat, commit, restart, evt;
        int ow, orr, op;
        beat = v & r; commit = 0; restart = 0; evt = 0;
        if (!m_act) begin
            if (beat && u) begin m_act = 1; m_line = 0; end
        end else if (beat && u) begin
            restart = 1; m_line = 0;
        end else if (beat && l) begin
            if (m_line == LINES - 1) begin commit = 1; m_line = 0; m_act = 0; end
            else m_line++;
        end
        m_err = restart;
        while (due.size() > 0 && due[0] <= cyc) begin
            if (due[0] == cyc) evt = 1;
            void'(due.pop_front());
        end
        ow = m_w; orr = m_r; op = m_p;
        if (commit && evt) begin
            m_r = ow; m_w = op; m_p = orr; m_fr = 0;
        end else if (commit) begin
            if (m_fr && m_drop < 65535) m_drop++;
            m_w = op; m_p = ow; m_fr = 1;
        end else if (evt && m_fr) begin
            m_r = op; m_p = orr; m_fr = 0;
        end
        // A level rising at this sampling edge becomes a read event SYNC edges later
        if (vs && !m_prev_vs) due.push_back(cyc + SYNC);
        m_prev_vs = vs;
    endtask

    task automatic drive(input bit iv, input bit ir, input bit iu, input bit il,
                         input bit ivs, input bit irn);
        exp_t e;
        @(posedge clk); #1;
        v = iv; r = ir; u = iu; l = il; vs = ivs; rstn = irn;
        cyc++;
        if (!irn) model_reset();
        e.w = 2'(m_w); e.r = 2'(m_r); e.fr = m_fr; e.err = m_err;
        e.we = m_act ? 1'b1 : (iv & iu);
        e.ln = 10'(m_line); e.dc = 16'(m_drop);
        exp_q.push_back(e);
        if (irn) model_step();
    endtask

    task automatic idle(input int n, input bit ivs);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, ivs, 1);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
    endtask

    task automatic frame(input bit ivs);
        drive(1, 1, 1, 0, ivs, 1);
        for (int i = 0; i < LINES; i++) drive(1, 1, 0, 1, ivs, 1);
    endtask

    // Monitor: pops one expectation per presented cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_bank", 16'(wr_bank), 16'(e.w));
                check("rd_bank", 16'(rd_bank), 16'(e.r));
                check("frame_ready", 16'(frame_ready), 16'(e.fr));
                check("err_short", 16'(err_short), 16'(e.err));
                check("wr_en", 16'(wr_en), 16'(e.we));
                check("line_cnt", 16'(line_cnt), 16'(e.ln));
`ifdef FRAME_DROP_CNT_EN
                check("drop_cnt", drop_val, e.dc);
`endif
            end
        end
    end

    initial begin
        int vs_timer, rst_hold;
        bit cur_vs, rv, rr, ru, rl, rn;
        model_reset();
        cyc = 0;
        do_reset();

        // One complete frame, no vsync
        frame(0);
        idle(2, 0);
        @(negedge clk);
        check("one_frame_ready", 16'(frame_ready), 16'd1);
        check("one_frame_wr", 16'(wr_bank), 16'd1);
        check("one_frame_rd", 16'(rd_bank), 16'd2);

        // vsync rise swaps in the pending frame; a second rise repeats it
        idle(4, 1);
        @(negedge clk);
        check("vsync_rd", 16'(rd_bank), 16'd0);
        check("vsync_ready", 16'(frame_ready), 16'd0);
        idle(3, 0);
        idle(5, 1);
        @(negedge clk);
        check("vsync_repeat_rd", 16'(rd_bank), 16'd0);

        // Short frame restart
        drive(1, 1, 1, 0, 1, 1);
        drive(1, 1, 0, 1, 1, 1);
        drive(1, 1, 0, 1, 1, 1);
        drive(1, 1, 1, 0, 1, 1);
        idle(1, 1);
        @(negedge clk);
        check("short_err", 16'(err_short), 16'd1);
        check("short_line", 16'(line_cnt), 16'd0);
        check("short_wr", 16'(wr_bank), 16'd1);
        idle(1, 1);
        @(negedge clk);
        check("short_err_pulse", 16'(err_short), 16'd0);

        // Two commits without a read: the first pending frame is dropped
        do_reset();
        frame(0);
        frame(0);
        idle(1, 0);
        @(negedge clk);
        check("drop_ready", 16'(frame_ready), 16'd1);
        check("drop_wr", 16'(wr_bank), 16'd0);
`ifdef FRAME_DROP_CNT_EN
        check("drop_cnt_one", drop_val, 16'd1);
`endif

        // Commit on the same edge as the synchronized read event
        do_reset();
        drive(1, 1, 1, 0, 0, 1);
        drive(1, 1, 0, 1, 0, 1);
        drive(1, 1, 0, 1, 1, 1);
        drive(1, 1, 0, 1, 1, 1);
        drive(1, 1, 0, 1, 1, 1);
        idle(1, 1);
        @(negedge clk);
        check("coinc_rd", 16'(rd_bank), 16'd0);
        check("coinc_wr", 16'(wr_bank), 16'd1);
        check("coinc_ready", 16'(frame_ready), 16'd0);

        // Reset mid-frame, then beats without tuser are ignored
        do_reset();
        drive(1, 1, 1, 0, 0, 1);
        drive(1, 1, 0, 1, 0, 1);
        drive(1, 1, 0, 1, 0, 1);
        drive(1, 1, 0, 1, 0, 0);
        @(negedge clk);
        check("rst_line", 16'(line_cnt), 16'd0);
        check("rst_wr", 16'(wr_bank), 16'd0);
        check("rst_rd", 16'(rd_bank), 16'd2);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 1, 0, 1);
        @(negedge clk);
        check("post_rst_line", 16'(line_cnt), 16'd0);

        // Random traffic
        vs_timer = 5; rst_hold = 0; cur_vs = 0;
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 9) < 8);
            rr = ($urandom_range(0, 9) < 8);
            ru = m_act ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0);
            rl = ($urandom_range(0, 2) == 0);
            if (vs_timer == 0) begin
                cur_vs = ~cur_vs;
                vs_timer = $urandom_range(2, 25);
            end else begin
                vs_timer--;
            end
            rn = 1;
            if (rst_hold > 0) begin
                rn = 0; rst_hold--;
            end else if ($urandom_range(0, 999) == 0) begin
                rn = 0; rst_hold = $urandom_range(0, 2);
            end
            drive(rv, rr, ru, rl, cur_vs, rn);
        end
        idle(2, cur_vs);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
